cgra_inst_fetch: RTL and testbench

//  Instruction sequencer/fetch stage directly upstream of the CGRA vector/scalar decoder.

---
 rtl/cgra_inst_fetch_pkg.sv | 37 +++
 rtl/cgra_imem.sv | 45 ++++
 rtl/cgra_inst_fetch.sv | 130 +++++++++++++
 tb/tb_cgra_inst_fetch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_inst_fetch_pkg.sv
// Shared constants and state encoding for the CGRA instruction fetch stage.
// Also holds the beq target arithmetic used by the sequencer.
package cgra_inst_fetch_pkg;

    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_AW     = 8;
    localparam int dwidth_inst = 32;
    localparam int BR_IMM_W    = 12;
    localparam int BR_OFF_W    = BR_IMM_W - 1;
    localparam int BR_SUM_W    = 13;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_VEC,
        DONE
    } fetch_state_e;

    // Below zero wraps modulo depth; past the 9-bit range saturates so it still terminates.
    function automatic logic [IMEM_AW:0] br_target(
        input logic [IMEM_AW-1:0]  pc,
        input logic [BR_OFF_W-1:0] off
    );
        logic signed [BR_SUM_W-1:0] sum;
        sum = $signed({{(BR_SUM_W-IMEM_AW){1'b0}}, pc})
            + $signed({{(BR_SUM_W-BR_OFF_W){off[BR_OFF_W-1]}}, off});
        if (sum[BR_SUM_W-1]) begin
            return {1'b0, sum[IMEM_AW-1:0]};
        end else if (|sum[BR_SUM_W-2:IMEM_AW+1]) begin
            return '1;
        end else begin
            return sum[IMEM_AW:0];
        end
    endfunction

endpackage

// File: rtl/cgra_imem.sv
// Simple dual-port instruction RAM: host write port, registered read port.
// Only the read register is reset; the array keeps its contents across reset.
module cgra_imem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cgra_inst_fetch.sv
// Instruction sequencer feeding the CGRA decoder: PC, branch, vector stall.
// The read register inside the IMEM doubles as the registered instr output.
module cgra_inst_fetch
    import cgra_inst_fetch_pkg::*;
(
    input  logic                   axis_aclk,
    input  logic                   axis_resetn,
    input  logic                   start,
    input  logic [IMEM_AW:0]       prog_len,
    input  logic                   imem_wr_en,
    input  logic [IMEM_AW-1:0]     imem_wr_addr,
    input  logic [dwidth_inst-1:0] imem_wr_data,
    output logic [dwidth_inst-1:0] instr,
    output logic                   instr_valid,
    input  logic                   is_beq,
    input  logic [BR_IMM_W-1:0]    branch_immediate,
    input  logic                   br_taken,
    input  logic                   is_not_vect,
    input  logic                   vec_done,
    output logic [IMEM_AW-1:0]     pc,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            inst_count
);

    fetch_state_e state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [IMEM_AW:0]   prog_len_q, prog_len_d;
    logic [31:0]        inst_count_q, inst_count_d;

    logic               rd_en;
    logic               wr_en_gated;
    logic [IMEM_AW:0]   npc;
    logic               pc_upd;

    assign busy        = (state_q == FETCH) || (state_q == ISSUE)
                      || (state_q == WAIT_VEC);
    assign done        = (state_q == DONE);
    assign instr_valid = (state_q == ISSUE);
    assign rd_en       = (state_q == FETCH);
    assign wr_en_gated = imem_wr_en & ~busy;
    assign pc          = pc_q;
    assign inst_count  = inst_count_q;

    cgra_imem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (IMEM_AW),
        .DW    (dwidth_inst)
    ) u_imem (
        .clk     (axis_aclk),
        .rst_n   (axis_resetn),
        .wr_en   (wr_en_gated),
        .wr_addr (imem_wr_addr),
        .wr_data (imem_wr_data),
        .rd_en   (rd_en),
        .rd_addr (pc_q),
        .rd_data (instr)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        prog_len_d   = prog_len_q;
        inst_count_d = inst_count_q;
        npc          = {1'b0, pc_q} + 1'b1;
        pc_upd       = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    prog_len_d   = prog_len;
                    inst_count_d = '0;
                    pc_d         = '0;
                    state_d      = (prog_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                if (!(&inst_count_q)) begin
                    inst_count_d = inst_count_q + 32'd1;
                end
                if (instr == '0) begin
                    state_d = DONE;
                end else if (!is_not_vect) begin
                    state_d = WAIT_VEC;
                end else begin
                    // Misaligned immediates fall through to pc+1.
                    if (is_beq && br_taken && !branch_immediate[0]) begin
                        npc = br_target(pc_q, branch_immediate[BR_IMM_W-1:1]);
                    end
                    pc_upd = 1'b1;
                end
            end
            WAIT_VEC: begin
                if (vec_done) begin
                    pc_upd = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pc_upd) begin
            if (npc >= prog_len_q) begin
                state_d = DONE;
            end else begin
                state_d = FETCH;
                pc_d    = npc[IMEM_AW-1:0];
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            prog_len_q   <= '0;
            inst_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            prog_len_q   <= prog_len_d;
            inst_count_q <= inst_count_d;
        end
    end

endmodule

// File: tb/tb_cgra_inst_fetch.sv
// Directed bench for cgra_inst_fetch: branch vector table plus hand sequences
// for vector stall, zero-word termination, reset mid-run and busy gating.
module tb_cgra_inst_fetch;
    import cgra_inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  prog_len;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        is_beq;
    logic [11:0] imm;
    logic        br_taken;
    logic        is_not_vect;
    logic        vec_done;
    logic [7:0]  pc;
    logic        busy;
    logic        done;
    logic [31:0] inst_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cgra_inst_fetch dut (
        .axis_aclk        (clk),
        .axis_resetn      (rst_n),
        .start            (start),
        .prog_len         (prog_len),
        .imem_wr_en       (wr_en),
        .imem_wr_addr     (wr_addr),
        .imem_wr_data     (wr_data),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .is_beq           (is_beq),
        .branch_immediate (imm),
        .br_taken         (br_taken),
        .is_not_vect      (is_not_vect),
        .vec_done         (vec_done),
        .pc               (pc),
        .busy             (busy),
        .done             (done),
        .inst_count       (inst_count)
    );

    typedef struct {
        logic [8:0]  plen;
        logic [7:0]  at;
        logic        beq;
        logic        tk;
        logic [11:0] imm;
        logic        exp_done;
        logic [7:0]  exp_pc;
    } bv_t;

    bv_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input int i);
        return (32'(i) << 20) | 32'h13;
    endfunction

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic go(input logic [8:0] plen);
        prog_len = plen;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_ev(output bit got, input int budget);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (instr_valid || done) begin
                got = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_issue_at(input logic [7:0] at, input int budget,
                                 output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (instr_valid && pc == at) begin
                got = 1'b1;
                return;
            end
            if (done) return;
            tick();
        end
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 2000; i++) begin
            if (done) break;
            tick();
        end
        chk(nm, done, 1'b1);
    endtask

    task automatic count_issues(input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            if (instr_valid) n++;
            if (done) return;
            tick();
        end
    endtask

    initial begin
        bit got;
        int n;
        int cyc;
        int last;
        bit seen;

        tbl[0]  = '{9'd8,   8'd4, 1'b1, 1'b1, 12'hFF8, 1'b0, 8'd0};
        tbl[1]  = '{9'd8,   8'd4, 1'b1, 1'b0, 12'hFF8, 1'b0, 8'd5};
        tbl[2]  = '{9'd6,   8'd1, 1'b0, 1'b1, 12'h004, 1'b0, 8'd2};
        tbl[3]  = '{9'd6,   8'd1, 1'b1, 1'b1, 12'h004, 1'b0, 8'd3};
        tbl[4]  = '{9'd6,   8'd1, 1'b1, 1'b1, 12'h007, 1'b0, 8'd2};
        tbl[5]  = '{9'd6,   8'd3, 1'b1, 1'b1, 12'h000, 1'b0, 8'd3};
        tbl[6]  = '{9'd10,  8'd2, 1'b1, 1'b1, 12'h00E, 1'b0, 8'd9};
        tbl[7]  = '{9'd10,  8'd2, 1'b1, 1'b1, 12'h010, 1'b1, 8'd0};
        tbl[8]  = '{9'd256, 8'd0, 1'b1, 1'b1, 12'hFFE, 1'b0, 8'd255};
        tbl[9]  = '{9'd10,  8'd0, 1'b1, 1'b1, 12'hFFE, 1'b1, 8'd0};
        tbl[10] = '{9'd256, 8'd0, 1'b1, 1'b1, 12'h7FE, 1'b1, 8'd0};
        tbl[11] = '{9'd4,   8'd1, 1'b1, 1'b1, 12'h800, 1'b0, 8'd1};

        rst_n = 1'b0; start = 1'b0; prog_len = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        is_beq = 1'b0; imm = '0; br_taken = 1'b0;
        is_not_vect = 1'b1; vec_done = 1'b0;
        repeat (3) tick();

        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pc", pc, 8'd0);
        chk("rst_cnt", inst_count, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 256; i++) wr(8'(i), word_of(i));

        // three scalar words, one issue every 2 cycles
        go(9'd3);
        n = 0; cyc = 0; last = 0;
        for (int i = 0; i < 40; i++) begin
            if (instr_valid) begin
                chk("t1_pc", pc, 32'(n));
                chk("t1_instr", instr, word_of(n));
                if (n == 0) chk("t1_first_lat", cyc, 1);
                else chk("t1_gap", cyc - last, 2);
                last = cyc;
                n++;
            end
            if (done) break;
            tick();
            cyc++;
        end
        chk("t1_issues", n, 3);
        chk("t1_done", done, 1'b1);
        chk("t1_busy", busy, 1'b0);
        chk("t1_cnt", inst_count, 32'd3);

        // vector stall; a vec_done during ISSUE must be dropped
        go(9'd2);
        wait_ev(got, 8);
        chk("t2_issue0", instr_valid, 1'b1);
        is_not_vect = 1'b0;
        vec_done    = 1'b1;
        tick();
        is_not_vect = 1'b1;
        vec_done    = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (instr_valid || !busy) seen = 1'b1;
            tick();
        end
        chk("t2_stall_held", seen, 1'b0);
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        n = 1;
        for (int i = 0; i < 6; i++) begin
            if (instr_valid) break;
            tick();
            n++;
        end
        chk("t2_resume_gap", n, 2);
        chk("t2_pc", pc, 8'd1);
        chk("t2_instr", instr, word_of(1));
        wait_done("t2_done");
        chk("t2_cnt", inst_count, 32'd2);

        // branch vector table
        foreach (tbl[k]) begin
            go(tbl[k].plen);
            wait_issue_at(tbl[k].at, 600, got);
            chk($sformatf("br%0d_reach", k), got, 1'b1);
            is_beq   = tbl[k].beq;
            br_taken = tbl[k].tk;
            imm      = tbl[k].imm;
            tick();
            is_beq = 1'b0; br_taken = 1'b0; imm = '0;
            wait_ev(got, 8);
            chk($sformatf("br%0d_done", k), done, tbl[k].exp_done);
            if (!tbl[k].exp_done) begin
                chk($sformatf("br%0d_pc", k), pc, tbl[k].exp_pc);
            end
            wait_done($sformatf("br%0d_end", k));
        end

        // empty program and zero-word termination
        go(9'd0);
        chk("t4_len0_done", done, 1'b1);
        chk("t4_len0_valid", instr_valid, 1'b0);
        chk("t4_len0_cnt", inst_count, 32'd0);
        wr(8'd1, 32'h0);
        go(9'd5);
        count_issues(40, n);
        chk("t4_zero_issues", n, 2);
        chk("t4_zero_done", done, 1'b1);
        chk("t4_zero_cnt", inst_count, 32'd2);
        wr(8'd1, word_of(1));

        // reset while stalled on a vector instr
        go(9'd4);
        wait_ev(got, 8);
        is_not_vect = 1'b0;
        tick();
        is_not_vect = 1'b1;
        repeat (3) tick();
        chk("t5_pre_busy", busy, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_instr", instr, 32'h0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_pc", pc, 8'd0);
        chk("t5_cnt", inst_count, 32'd0);
        chk("t5_valid", instr_valid, 1'b0);
        tick();
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("t5_idle_busy", busy, 1'b0);
        go(9'd1);
        wait_ev(got, 8);
        chk("t5_reissue", instr, word_of(0));
        wait_done("t5_end");

        // start and host writes while busy are ignored
        go(9'd4);
        wait_ev(got, 8);
        tick();
        start = 1'b1;
        wr_en = 1'b1; wr_addr = 8'd0; wr_data = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        count_issues(60, n);
        chk("t6_issues", n, 3);
        chk("t6_cnt", inst_count, 32'd4);
        go(9'd1);
        wait_ev(got, 8);
        chk("t6_readback", instr, word_of(0));
        wait_done("t6_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
